// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM encoding,
// requester-index width helper and the default multiplier latency.
package mult_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH_B = 16;

  // Cycles from the multiplier sampling start to rdy rising.
  localparam int MULT_LAT = 2 ** $clog2(DEF_WIDTH_B);

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/Multiplier_signed.sv
// Sequential shift-add multiplier: signed A times unsigned B, one bit of B
// per clock. The first bit is consumed on the start edge, so rdy rises
// 2^clog2(WIDTH_B) edges after start is sampled (start edge included).
// No reset: rdy stays high after completion until the next start.
module Multiplier_signed #(
  parameter int WIDTH_A = 17,
  parameter int WIDTH_B = 16
) (
  input  logic                              clk,
  input  logic                              start,
  input  logic signed [WIDTH_A-1:0]         a,
  input  logic        [WIDTH_B-1:0]         b,
  output logic signed [WIDTH_A+WIDTH_B-1:0] y,
  output logic                              rdy
);

  localparam int LAT = 2 ** $clog2(WIDTH_B);
  localparam int PW  = WIDTH_A + WIDTH_B;
  localparam int CW  = $clog2(LAT + 1);

  logic signed [PW-1:0]  acc;
  logic signed [PW-1:0]  mcand;
  logic signed [PW-1:0]  a_ext;
  logic        [LAT-1:0] mplier;
  logic        [LAT-1:0] b_ext;
  logic        [CW-1:0]  cnt;

  assign a_ext = {{WIDTH_B{a[WIDTH_A-1]}}, a};
  assign b_ext = LAT'(b);
  assign y     = acc;

  // Load and first partial product on start, then one B bit per cycle.
  always_ff @(posedge clk) begin
    if (start) begin
      acc    <= b_ext[0] ? a_ext : '0;
      mcand  <= a_ext <<< 1;
      mplier <= b_ext >> 1;
      cnt    <= CW'(LAT - 1);
      rdy    <= (LAT == 1);
    end else if (cnt != '0) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand <<< 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      rdy    <= (cnt == CW'(1));
    end
  end

endmodule

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after
// the pointer, wrapping modulo N. Returns a one-hot grant and its index.
module mult_share_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the pointer, wrapping, and keep the first hit.
  always_comb begin
    int k;
    k     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        grant[k] = 1'b1;
        idx      = IW'(k);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one sequential signed multiplier between N_REQ requesters.
// Round-robin grant, operands latched and sign-conditioned so the
// multiplier's B input is never negative, result returned with a
// one-cycle ack to the owner.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 16
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [N_REQ-1:0]                    req_i,
  input  logic [N_REQ*WIDTH_A-1:0]            a_i,
  input  logic [N_REQ*WIDTH_B-1:0]            b_i,
  output logic [N_REQ-1:0]                    ack_o,
  output logic signed [WIDTH_A+WIDTH_B-1:0]   y_o,
  output logic                                y_valid_o,
  output logic [id_width(N_REQ)-1:0]          y_id_o,
  output logic                                busy_o
);

  localparam int IW = id_width(N_REQ);
  localparam int PW = WIDTH_A + WIDTH_B;

  // Negative B: negate both operands so B becomes a non-negative
  // magnitude; A gets one extra bit so -(-2^(WIDTH_A-1)) fits.
  function automatic logic signed [WIDTH_A:0] cond_a(
    input logic signed [WIDTH_A-1:0] a,
    input logic                      b_neg
  );
    logic signed [WIDTH_A:0] ext;
    ext = {a[WIDTH_A-1], a};
    return b_neg ? -ext : ext;
  endfunction

  function automatic logic [WIDTH_B-1:0] cond_b(
    input logic signed [WIDTH_B-1:0] b
  );
    logic signed [WIDTH_B-1:0] neg;
    neg = -b;
    return b[WIDTH_B-1] ? neg : b;
  endfunction

  // Signed operand ranges keep the true product within PW bits.
  function automatic logic signed [PW-1:0] trunc_product(
    input logic signed [PW:0] p
  );
    return signed'(p[PW-1:0]);
  endfunction

  state_t                    state;
  state_t                    state_nx;
  logic                      grab;
  logic                      start_r;
  logic [IW-1:0]             rr_ptr;
  logic [IW-1:0]             id;
  logic [N_REQ-1:0]          owner;
  logic [N_REQ-1:0]          pick_grant;
  logic [IW-1:0]             pick_idx;
  logic                      pick_any;
  logic signed [WIDTH_A-1:0] a_sel;
  logic signed [WIDTH_B-1:0] b_sel;
  logic signed [WIDTH_A:0]   a_p0;
  logic        [WIDTH_B-1:0] b_p0;
  logic signed [PW:0]        mult_y;
  logic                      mult_rdy;

  mult_share_arbiter_rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req_i),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign a_sel = a_i[int'(pick_idx)*WIDTH_A +: WIDTH_A];
  assign b_sel = b_i[int'(pick_idx)*WIDTH_B +: WIDTH_B];

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state; rdy is ignored while start_r is high because the
  // multiplier's rdy is still stale from the previous operation then.
  always_comb begin
    state_nx = state;
    grab     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          grab     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (!start_r && mult_rdy) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0: latch the winner's conditioned operands at grant.
  always_ff @(posedge clk_i) begin
    if (grab) begin
      a_p0 <= cond_a(a_sel, b_sel[WIDTH_B-1]);
      b_p0 <= cond_b(b_sel);
    end
  end

  Multiplier_signed #(
    .WIDTH_A (WIDTH_A + 1),
    .WIDTH_B (WIDTH_B)
  ) u_mult (
    .clk   (clk_i),
    .start (start_r),
    .a     (a_p0),
    .b     (b_p0),
    .y     (mult_y),
    .rdy   (mult_rdy)
  );

  // Grant bookkeeping, start pulse, busy, and result/ack capture in DONE.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr    <= '0;
      id        <= '0;
      owner     <= '0;
      start_r   <= 1'b0;
      busy_o    <= 1'b0;
      ack_o     <= '0;
      y_valid_o <= 1'b0;
      y_id_o    <= '0;
      y_o       <= '0;
    end else begin
      start_r   <= grab;
      ack_o     <= '0;
      y_valid_o <= 1'b0;
      if (grab) begin
        id     <= pick_idx;
        owner  <= pick_grant;
        rr_ptr <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
        busy_o <= 1'b1;
      end else if (y_valid_o) begin
        busy_o <= 1'b0;
      end
      if (state == DONE) begin
        ack_o     <= owner;
        y_valid_o <= 1'b1;
        y_id_o    <= id;
        y_o       <= trunc_product(mult_y);
      end
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed + randomized bench for mult_share_arbiter with a round-robin /
// arithmetic reference model.
module tb_mult_share_arbiter;
  import mult_share_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int WA  = 16;
  localparam int WB  = 16;
  localparam int LAT = MULT_LAT + 2;

  logic          clk;
  logic          reset_i;
  logic [N-1:0]  req_i;
  logic [N*WA-1:0] a_i;
  logic [N*WB-1:0] b_i;
  logic [N-1:0]  ack_o;
  logic [WA+WB-1:0] y_o;
  logic          y_valid_o;
  logic [1:0]    y_id_o;
  logic          busy_o;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  int model_ptr = 0;

  mult_share_arbiter #(.N_REQ(N), .WIDTH_A(WA), .WIDTH_B(WB)) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .req_i     (req_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .ack_o     (ack_o),
    .y_o       (y_o),
    .y_valid_o (y_valid_o),
    .y_id_o    (y_id_o),
    .busy_o    (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first pending requester at or after the pointer.
  function automatic int model_pick(input logic [N-1:0] pend, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (pend[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  // Full signed product of requester k's current operands.
  function automatic logic [31:0] ref_prod(input int k);
    logic signed [WA-1:0] a;
    logic signed [WB-1:0] b;
    longint p;
    a = a_i[k*WA +: WA];
    b = b_i[k*WB +: WB];
    p = longint'(a) * longint'(b);
    return p[31:0];
  endfunction

  task automatic set_ops(input int k, input logic [15:0] a, input logic [15:0] b);
    a_i[k*WA +: WA] = a;
    b_i[k*WB +: WB] = b;
  endtask

  function automatic logic [15:0] rand_op();
    if ($urandom_range(0, 3) == 0) return 16'h8000;
    return 16'($urandom);
  endfunction

  task automatic do_reset();
    reset_i = 1'b1;
    req_i   = '0;
    tick();
    tick();
    reset_i   = 1'b0;
    model_ptr = 0;
  endtask

  // One operation: the next edge must grant; result checked LAT cycles on.
  task automatic op_check(input string tag, input logic [N-1:0] raise, input bit mutate);
    int id;
    int lat;
    int busy_low;
    logic [31:0] y_exp;
    logic [N-1:0] ack_exp;
    id        = model_pick(req_i, model_ptr);
    y_exp     = ref_prod(id);
    model_ptr = (id + 1) % N;
    ack_exp   = N'(1 << id);
    tick();
    check({tag, " busy_at_grant"}, 64'(busy_o), 64'(1));
    req_i = req_i | raise;
    if (mutate) begin
      req_i[id] = 1'b0;
      set_ops(id, 16'($urandom), 16'($urandom));
    end
    lat = 0;
    busy_low = 0;
    while (!y_valid_o && lat < 40) begin
      tick();
      lat++;
      if (!busy_o) busy_low++;
    end
    check({tag, " latency"}, 64'(lat), 64'(LAT));
    check({tag, " busy_low_cycles"}, 64'(busy_low), 64'(0));
    check({tag, " ack"}, 64'(ack_o), 64'(ack_exp));
    check({tag, " y"}, 64'(y_o), 64'(y_exp));
    check({tag, " y_id"}, 64'(y_id_o), 64'(id));
  endtask

  initial begin
    int n;
    reset_i = 1'b1;
    req_i   = '0;
    a_i     = '0;
    b_i     = '0;
    tick();
    tick();
    tick();
    check("reset ack", 64'(ack_o), 64'(0));
    check("reset y", 64'(y_o), 64'(0));
    check("reset y_valid", 64'(y_valid_o), 64'(0));
    check("reset y_id", 64'(y_id_o), 64'(0));
    check("reset busy", 64'(busy_o), 64'(0));
    reset_i = 1'b0;
    model_ptr = 0;

    // No requests: stays idle.
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy_o || y_valid_o || ack_o != '0) n++;
    end
    check("idle activity", 64'(n), 64'(0));

    // Single op on requester 2.
    set_ops(2, 16'hFFFD, 16'd7);
    req_i = 4'b0100;
    op_check("single", '0, 1'b0);
    check("single y const", 64'(y_o), 64'(32'hFFFF_FFEB));
    req_i = '0;
    tick();
    check("post ack", 64'(ack_o), 64'(0));
    check("post y_valid", 64'(y_valid_o), 64'(0));
    check("post busy", 64'(busy_o), 64'(0));
    check("post y hold", 64'(y_o), 64'(32'hFFFF_FFEB));
    check("post id hold", 64'(y_id_o), 64'(2));

    // Operand extremes on requester 1.
    set_ops(1, 16'h8000, 16'h8000);
    req_i = 4'b0010;
    op_check("ext_min_min", '0, 1'b0);
    check("ext_min_min const", 64'(y_o), 64'(32'h4000_0000));
    set_ops(1, 16'h7FFF, 16'h8000);
    op_check("ext_max_min", '0, 1'b0);
    check("ext_max_min const", 64'(y_o), 64'(32'hC000_8000));
    set_ops(1, 16'h0000, 16'hFFFF);
    op_check("ext_zero_neg", '0, 1'b0);
    check("ext_zero_neg const", 64'(y_o), 64'(0));
    req_i = '0;
    tick();

    // Owner changes operands and drops req after grant.
    set_ops(0, 16'd1234, 16'hFF85);
    req_i = 4'b0001;
    op_check("mutate", '0, 1'b1);
    req_i = '0;
    tick();

    // Randomized masks and operands against the model.
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < N; k++) set_ops(k, rand_op(), rand_op());
      req_i = N'($urandom_range(1, 15));
      op_check("random", '0, 1'b0);
    end
    req_i = '0;
    tick();

    // All four held: order 0,1,2,3,0 back to back.
    do_reset();
    for (int k = 0; k < N; k++) set_ops(k, rand_op(), rand_op());
    req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      op_check("all4", '0, 1'b0);
      check("all4 order", 64'(y_id_o), 64'(i % N));
    end
    req_i = '0;
    tick();

    // Fairness: req0 held, req3 raised during op 0.
    do_reset();
    set_ops(0, 16'd300, 16'hFFF0);
    set_ops(3, 16'hF000, 16'd9);
    req_i = 4'b0001;
    op_check("rr op0", 4'b1000, 1'b0);
    req_i[3] = 1'b1;
    op_check("rr op3", '0, 1'b0);
    check("rr second id", 64'(y_id_o), 64'(3));
    req_i[3] = 1'b0;
    op_check("rr op0b", '0, 1'b0);
    check("rr third id", 64'(y_id_o), 64'(0));
    req_i = '0;
    tick();

    // Reset during RUN aborts the op.
    set_ops(1, 16'd1000, 16'd2000);
    req_i = 4'b0010;
    tick();
    check("abort busy", 64'(busy_o), 64'(1));
    for (int i = 0; i < 8; i++) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    req_i   = '0;
    model_ptr = 0;
    check("abort ack", 64'(ack_o), 64'(0));
    check("abort y", 64'(y_o), 64'(0));
    check("abort y_valid", 64'(y_valid_o), 64'(0));
    check("abort y_id", 64'(y_id_o), 64'(0));
    check("abort busy_cleared", 64'(busy_o), 64'(0));
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (y_valid_o || ack_o != '0) n++;
    end
    check("abort no ack", 64'(n), 64'(0));
    set_ops(3, 16'd5, 16'hFFFB);
    req_i = 4'b1000;
    op_check("after_abort", '0, 1'b0);
    check("after_abort const", 64'(y_o), 64'(32'hFFFF_FFE7));
    req_i = '0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
